// File: rtl/core_pkg.sv
// core_pkg: definitions shared by the BMEM loader and unloader in core.
// Holds command opcodes, the BMEM header byte, the unloader FSM states and
// the default tile geometry. When BMEM_UNLOADER_CHECKSUM_EN is defined the
// state list also carries the checksum state.
package core_pkg;

    // Default geometry of the core build.
    localparam int CORE_BITWIDTH  = 32;
    localparam int CORE_MESHUNITS = 2;
    localparam int CORE_TILEUNITS = 2;

    // Derived sizes shared by the loader and the unloader.
    localparam int BYTES      = CORE_BITWIDTH / 8;
    localparam int TILE_WORDS = CORE_MESHUNITS * CORE_MESHUNITS * CORE_TILEUNITS * CORE_TILEUNITS;

    // Two-bit command opcodes carried in header bits [7:6].
    typedef enum logic [1:0] {
        CMD_INVALID = 2'b00,
        CMD_IMEM    = 2'b01,
        CMD_BMEM    = 2'b10,
        CMD_UPDATE  = 2'b11
    } cmd_op_t;

    // BMEM frame header: opcode in [7:6], zeros below.
    localparam logic [7:0] HDR_BMEM = 8'h80;

    // Unloader FSM states.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_READ    = 4'd1,
        ST_CAPTURE = 4'd2,
        ST_LOCK    = 4'd3,
        ST_HEADER  = 4'd4,
        ST_ADDR    = 4'd5,
        ST_DATA    = 4'd6,
`ifdef BMEM_UNLOADER_CHECKSUM_EN
        ST_CSUM    = 4'd7,
`endif
        ST_RELEASE = 4'd8
    } unload_state_t;

    // Bytes per word for a given word width.
    function automatic int bytes_of(input int bitwidth);
        return bitwidth / 8;
    endfunction

    // Words per tile for a given mesh/tile geometry.
    function automatic int tile_words_of(input int meshunits, input int tileunits);
        return meshunits * meshunits * tileunits * tileunits;
    endfunction

endpackage

// File: rtl/bmem_unloader.sv
// bmem_unloader: reads one BMEM tile in a single access and streams it to the
// host as a BMEM frame (header, little-endian address, tile bytes) over the
// shared UART write port, holding the write lock for the whole frame.
// Optional feature: define BMEM_UNLOADER_CHECKSUM_EN to append one XOR byte
// over the address and data bytes.
module bmem_unloader
    import core_pkg::*;
#(
    parameter int BITWIDTH  = 32,
    parameter int MESHUNITS = 2,
    parameter int TILEUNITS = 2
) (
    input  logic                                                   clock,
    input  logic                                                   reset,
    input  logic                                                   dump_req,
    input  logic [BITWIDTH-1:0]                                    dump_addr,
    output logic                                                   dump_busy,
    output logic                                                   dump_done,
    output logic [BITWIDTH-1:0]                                    bmem_read_addr,
    output logic                                                   bmem_read_valid,
    input  logic [tile_words_of(MESHUNITS, TILEUNITS)*BITWIDTH-1:0] bmem_read_data,
    output logic                                                   write_lock_req,
    input  logic                                                   write_lock_res,
    input  logic                                                   write_ready,
    output logic [7:0]                                             data_in,
    output logic                                                   data_in_valid
);

    localparam int NBYTES     = bytes_of(BITWIDTH);
    localparam int NWORDS     = tile_words_of(MESHUNITS, TILEUNITS);
    localparam int TILE_BITS  = NWORDS * BITWIDTH;
    localparam int TILE_BYTES = NWORDS * NBYTES;
    localparam int AIDX_W     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TIDX_W     = (TILE_BYTES > 1) ? $clog2(TILE_BYTES) : 1;
    localparam logic [BITWIDTH-1:0] LAST_ADDR_BYTE = BITWIDTH'(NBYTES - 1);
    localparam logic [BITWIDTH-1:0] LAST_DATA_BYTE = BITWIDTH'(TILE_BYTES - 1);

    unload_state_t           state_r;
    unload_state_t           state_nxt_s;
    logic [BITWIDTH-1:0]     addr_r;
    logic [TILE_BITS-1:0]    tile_r;
    logic [BITWIDTH-1:0]     cnt_r;
    logic                    accept_s;
    logic                    capture_s;
    logic                    cnt_clr_s;
    logic                    cnt_inc_s;
    logic                    sending_s;
    logic                    xfer_s;
    logic [7:0]              byte_s;
`ifdef BMEM_UNLOADER_CHECKSUM_EN
    logic [7:0]              csum_r;
    logic                    csum_acc_s;
`endif

    // A byte moves only while granted, presenting and accepted by the UART.
    assign xfer_s = sending_s && write_lock_res && write_ready;

    // Next-state logic, datapath controls and state-decoded outputs.
    always_comb begin
        state_nxt_s     = state_r;
        accept_s        = 1'b0;
        capture_s       = 1'b0;
        cnt_clr_s       = 1'b0;
        cnt_inc_s       = 1'b0;
        sending_s       = 1'b0;
        byte_s          = 8'h00;
        dump_busy       = 1'b1;
        dump_done       = 1'b0;
        bmem_read_valid = 1'b0;
        write_lock_req  = 1'b0;
`ifdef BMEM_UNLOADER_CHECKSUM_EN
        csum_acc_s      = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                dump_busy = 1'b0;
                if (dump_req) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                bmem_read_valid = 1'b1;
                state_nxt_s     = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                capture_s   = 1'b1;
                state_nxt_s = ST_LOCK;
            end
            ST_LOCK: begin
                write_lock_req = 1'b1;
                if (write_lock_res) begin
                    state_nxt_s = ST_HEADER;
                end else begin
                    state_nxt_s = ST_LOCK;
                end
            end
            ST_HEADER: begin
                write_lock_req = 1'b1;
                sending_s      = 1'b1;
                byte_s         = HDR_BMEM;
                if (xfer_s) begin
                    cnt_clr_s   = 1'b1;
                    state_nxt_s = ST_ADDR;
                end else begin
                    state_nxt_s = ST_HEADER;
                end
            end
            ST_ADDR: begin
                write_lock_req = 1'b1;
                sending_s      = 1'b1;
                byte_s         = addr_r[{cnt_r[AIDX_W-1:0], 3'b000} +: 8];
                if (xfer_s) begin
`ifdef BMEM_UNLOADER_CHECKSUM_EN
                    csum_acc_s = 1'b1;
`endif
                    if (cnt_r == LAST_ADDR_BYTE) begin
                        cnt_clr_s   = 1'b1;
                        state_nxt_s = ST_DATA;
                    end else begin
                        cnt_inc_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                write_lock_req = 1'b1;
                sending_s      = 1'b1;
                byte_s         = tile_r[{cnt_r[TIDX_W-1:0], 3'b000} +: 8];
                if (xfer_s) begin
`ifdef BMEM_UNLOADER_CHECKSUM_EN
                    csum_acc_s = 1'b1;
`endif
                    if (cnt_r == LAST_DATA_BYTE) begin
`ifdef BMEM_UNLOADER_CHECKSUM_EN
                        state_nxt_s = ST_CSUM;
`else
                        state_nxt_s = ST_RELEASE;
`endif
                    end else begin
                        cnt_inc_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
`ifdef BMEM_UNLOADER_CHECKSUM_EN
            ST_CSUM: begin
                write_lock_req = 1'b1;
                sending_s      = 1'b1;
                byte_s         = csum_r;
                if (xfer_s) begin
                    state_nxt_s = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_CSUM;
                end
            end
`endif
            ST_RELEASE: begin
                dump_busy   = 1'b0;
                dump_done   = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                dump_busy   = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
        // Outside grant the byte is withdrawn but its position is held.
        data_in_valid = sending_s && write_lock_res;
        data_in       = byte_s;
    end

    assign bmem_read_addr = addr_r;

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Latch the requested address and the tile read back from blockmem.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_r <= '0;
            tile_r <= '0;
        end else begin
            if (accept_s) begin
                addr_r <= dump_addr;
            end
            if (capture_s) begin
                tile_r <= bmem_read_data;
            end
        end
    end

    // Byte counter within the ADDR and DATA phases.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (cnt_clr_s) begin
            cnt_r <= '0;
        end else if (cnt_inc_s) begin
            cnt_r <= cnt_r + BITWIDTH'(1);
        end
    end

`ifdef BMEM_UNLOADER_CHECKSUM_EN
    // Running XOR of every address and data byte sent in this frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            csum_r <= 8'h00;
        end else if (accept_s) begin
            csum_r <= 8'h00;
        end else if (csum_acc_s) begin
            csum_r <= csum_r ^ byte_s;
        end
    end
`endif

endmodule
